sobel_frame_seq: RTL and testbench

Frame-level controller for the RGB→YCbCr→Sobel image pipeline. It issues begin pulses to the video-stream source and runs N frames, or runs continuously. It applies the edge threshold only at frame boundaries, so a frame never mixes two thresholds. It monitors the Sobel output stream for resolution errors and stalls, and sits beside the datapath with its begin pulse driving the source and its threshold output driving the Sobel stage.

---
 rtl/sobel_seq_pkg.sv | 20 ++
 rtl/frame_res_meter.sv | 63 ++++++
 rtl/sobel_frame_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_sobel_frame_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_seq_pkg.sv
// rtl/sobel_seq_pkg.sv - shared types and constants for the sobel frame sequencer
package sobel_seq_pkg;

  localparam int RES_W = 16;
  localparam logic [7:0] THRESH_DEF = 8'd128;

  typedef enum logic [2:0] {
    IDLE,
    BEGIN,
    WAIT_SOF,
    ACTIVE,
    GAP
  } state_e;

  // increment that sticks at all-ones instead of wrapping
  function automatic logic [RES_W-1:0] sat_inc(input logic [RES_W-1:0] v);
    return (v == {RES_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/frame_res_meter.sv
// rtl/frame_res_meter.sv - sync edge detection and per-frame line/pixel measurement
module frame_res_meter
  import sobel_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,         // counting enabled while the frame is active
  input  logic             clr_i,        // start-of-frame clear of both counters
  input  logic             mon_vsync_i,
  input  logic             mon_hsync_i,
  input  logic             mon_valid_i,
  input  logic [RES_W-1:0] exp_xres_i,
  output logic             vs_rise_o,
  output logic             vs_fall_o,
  output logic             line_done_o,  // a non-empty line just closed
  output logic             first_line_o, // no line has closed yet in this frame
  output logic             line_bad_o,   // closing line width differs from expected
  output logic [RES_W-1:0] line_width_o,
  output logic [RES_W-1:0] line_total_o  // line count including a line closing now
);

  logic             vsync_q;
  logic             hsync_q;
  logic [RES_W-1:0] pix_q;
  logic [RES_W-1:0] line_q;
  logic             hs_fall;

  // one cycle of sync history; edges compare it with the live input
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      vsync_q <= mon_vsync_i;
      hsync_q <= mon_hsync_i;
    end
  end

  assign vs_rise_o    = mon_vsync_i & ~vsync_q;
  assign vs_fall_o    = ~mon_vsync_i & vsync_q;
  assign hs_fall      = ~mon_hsync_i & hsync_q;
  assign line_done_o  = en_i & hs_fall & (pix_q != '0);
  assign first_line_o = (line_q == '0);
  assign line_width_o = pix_q;
  assign line_bad_o   = line_done_o & (pix_q != exp_xres_i);
  assign line_total_o = line_done_o ? sat_inc(line_q) : line_q;

  // pixel count per line and closed-line count per frame, both saturating
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      pix_q  <= '0;
      line_q <= '0;
    end else if (en_i) begin
      if (hs_fall) begin
        pix_q <= mon_valid_i ? RES_W'(1) : '0;
      end else if (mon_valid_i) begin
        pix_q <= sat_inc(pix_q);
      end
      line_q <= line_total_o;
    end
  end

endmodule

// File: rtl/sobel_frame_seq.sv
// rtl/sobel_frame_seq.sv - frame sequencer: begin pulses, threshold hand-off, stream monitor
module sobel_frame_seq
  import sobel_seq_pkg::*;
#(
  parameter int BEGIN_LEN   = 5,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       num_frames,
  input  logic [7:0]       thresh_cfg,
  input  logic             thresh_wr,
  input  logic [RES_W-1:0] exp_xres,
  input  logic [RES_W-1:0] exp_yres,
  output logic             src_begin,
  input  logic             src_done,
  input  logic             mon_vsync,
  input  logic             mon_hsync,
  input  logic             mon_valid,
  output logic [7:0]       thresh_out,
  output logic             busy,
  output logic [7:0]       frame_cnt,
  output logic [RES_W-1:0] meas_xres,
  output logic [RES_W-1:0] meas_yres,
  output logic             err_res,
  output logic             err_timeout,
  output logic             run_done
);

  localparam int BW = $clog2(BEGIN_LEN + 2);
  localparam int GW = $clog2(GAP_CYC + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [BW-1:0] BEGIN_LAST = BW'(BEGIN_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  state_e           state_q;
  logic             src_begin_q;
  logic [7:0]       thresh_q;
  logic [7:0]       pend_q;
  logic [7:0]       frame_cnt_q;
  logic [RES_W-1:0] meas_x_q;
  logic [RES_W-1:0] meas_y_q;
  logic             err_res_q;
  logic             err_to_q;
  logic             run_done_q;
  logic             stop_q;
  logic             done_q;
  logic             done_seen_q;
  logic [BW-1:0]    begin_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic [TW-1:0]    to_cnt_q;

  logic             done_rise;
  logic             vs_rise;
  logic             vs_fall;
  logic             line_done;
  logic             first_line;
  logic             line_bad;
  logic [RES_W-1:0] line_width;
  logic [RES_W-1:0] line_total;

  frame_res_meter u_meter (
    .clk          (clk),
    .rst          (rst),
    .en_i         (state_q == ACTIVE),
    .clr_i        ((state_q == WAIT_SOF) && vs_rise),
    .mon_vsync_i  (mon_vsync),
    .mon_hsync_i  (mon_hsync),
    .mon_valid_i  (mon_valid),
    .exp_xres_i   (exp_xres),
    .vs_rise_o    (vs_rise),
    .vs_fall_o    (vs_fall),
    .line_done_o  (line_done),
    .first_line_o (first_line),
    .line_bad_o   (line_bad),
    .line_width_o (line_width),
    .line_total_o (line_total)
  );

  assign done_rise = src_done & ~done_q;

  // src_done history for rise detection
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= src_done;
    end
  end

  // run/frame state machine with all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_begin_q <= 1'b0;
      thresh_q    <= THRESH_DEF;
      pend_q      <= THRESH_DEF;
      frame_cnt_q <= '0;
      meas_x_q    <= '0;
      meas_y_q    <= '0;
      err_res_q   <= 1'b0;
      err_to_q    <= 1'b0;
      run_done_q  <= 1'b0;
      stop_q      <= 1'b0;
      done_seen_q <= 1'b0;
      begin_cnt_q <= '0;
      gap_cnt_q   <= '0;
      to_cnt_q    <= '0;
    end else begin
      run_done_q <= 1'b0;
      if (thresh_wr) begin
        pend_q <= thresh_cfg;
      end
      if (state_q != IDLE) begin
        if (stop) begin
          stop_q <= 1'b1;
        end
        if (done_rise) begin
          done_seen_q <= 1'b1;
        end
      end
      case (state_q)
        IDLE: begin
          thresh_q <= pend_q;
          if (start && !stop) begin
            frame_cnt_q <= '0;
            meas_x_q    <= '0;
            meas_y_q    <= '0;
            err_res_q   <= 1'b0;
            err_to_q    <= 1'b0;
            stop_q      <= 1'b0;
            done_seen_q <= 1'b0;
            begin_cnt_q <= '0;
            src_begin_q <= 1'b1;
            state_q     <= BEGIN;
          end
        end
        BEGIN: begin
          if (begin_cnt_q == BEGIN_LAST) begin
            src_begin_q <= 1'b0;
            to_cnt_q    <= '0;
            state_q     <= WAIT_SOF;
          end else begin
            begin_cnt_q <= begin_cnt_q + 1'b1;
          end
        end
        WAIT_SOF: begin
          if (vs_rise) begin
            thresh_q <= pend_q;
            to_cnt_q <= '0;
            state_q  <= ACTIVE;
          end else if (mon_valid) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            err_to_q   <= 1'b1;
            run_done_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        ACTIVE: begin
          if (line_done && first_line) begin
            meas_x_q <= line_width;
          end
          if (line_bad) begin
            err_res_q <= 1'b1;
          end
          if (vs_fall) begin
            meas_y_q <= line_total;
            if (line_total != exp_yres) begin
              err_res_q <= 1'b1;
            end
            frame_cnt_q <= frame_cnt_q + 1'b1;
            gap_cnt_q   <= '0;
            state_q     <= GAP;
          end else if (mon_valid) begin
            to_cnt_q <= '0;
          end else if (to_cnt_q == TO_LAST) begin
            err_to_q   <= 1'b1;
            run_done_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        GAP: begin
          if ((gap_cnt_q == GAP_LAST) && (done_seen_q || done_rise)) begin
            if (stop_q || stop || ((num_frames != 8'd0) && (frame_cnt_q == num_frames))) begin
              run_done_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              done_seen_q <= 1'b0;
              begin_cnt_q <= '0;
              src_begin_q <= 1'b1;
              state_q     <= BEGIN;
            end
          end else if (gap_cnt_q != GAP_LAST) begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // the begin pulse is cut by reset without waiting for a clock edge
  assign src_begin   = src_begin_q & ~rst;
  assign thresh_out  = thresh_q;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;
  assign meas_xres   = meas_x_q;
  assign meas_yres   = meas_y_q;
  assign err_res     = err_res_q;
  assign err_timeout = err_to_q;
  assign run_done    = run_done_q;

endmodule

// File: tb/tb_sobel_frame_seq.sv
// tb/tb_sobel_frame_seq.sv - self-checking bench for sobel_frame_seq
module tb_sobel_frame_seq;

  localparam int BL   = 5;
  localparam int GC   = 16;
  localparam int TO   = 100;
  localparam int MAXL = 8;

  logic        clk = 1'b0;
  logic        rst, start, stop, thresh_wr, src_done;
  logic        mon_vsync, mon_hsync, mon_valid;
  logic [7:0]  num_frames, thresh_cfg, thresh_out, frame_cnt;
  logic [15:0] exp_xres, exp_yres, meas_xres, meas_yres;
  logic        src_begin, busy, err_res, err_timeout, run_done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model of the run, expressed as frame-level facts
  int m_cnt, m_mx, m_my, thr_cur, thr_next;
  bit m_err;

  typedef int wl_t [MAXL];

  typedef struct {
    int nf, xr, yr, nl, bad_line, bad_w, wr_frame, wr_line, wr_val;
    int e_cnt, e_mx, e_my;
    bit e_err;
  } vec_t;

  vec_t vec [5];

  sobel_frame_seq #(.BEGIN_LEN(BL), .GAP_CYC(GC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .num_frames(num_frames),
    .thresh_cfg(thresh_cfg), .thresh_wr(thresh_wr), .exp_xres(exp_xres), .exp_yres(exp_yres),
    .src_begin(src_begin), .src_done(src_done), .mon_vsync(mon_vsync), .mon_hsync(mon_hsync),
    .mon_valid(mon_valid), .thresh_out(thresh_out), .busy(busy), .frame_cnt(frame_cnt),
    .meas_xres(meas_xres), .meas_yres(meas_yres), .err_res(err_res),
    .err_timeout(err_timeout), .run_done(run_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_begin();
    int t = 0;
    int len = 0;
    while (!src_begin && t < 300) begin tick(); t++; end
    chk("begin_seen", (t < 300), 1);
    while (src_begin && len < 50) begin tick(); len++; end
    chk("begin_len", len, BL);
  endtask

  task automatic run(input int nf, input int xr, input int yr);
    exp_xres = 16'(xr); exp_yres = 16'(yr); num_frames = 8'(nf);
    start = 1'b1; tick(); start = 1'b0;
    m_cnt = 0; m_mx = 0; m_my = 0; m_err = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_clr_cnt", frame_cnt, 0);
    chk("start_clr_err", {err_res, err_timeout}, 0);
    chk("start_clr_meas", {meas_xres, meas_yres}, 0);
  endtask

  // one complete frame from the source side, updating the model afterwards
  task automatic do_frame(input int nl, input wl_t w, input int wr_line, input int wr_val,
                          input int stop_line);
    int lines = 0;
    int first = -1;
    bit bad = 1'b0;
    wait_begin();
    tick(2);
    chk("thr_pre_sof", thresh_out, thr_cur);
    if (wr_line == -2) begin thresh_cfg = 8'(wr_val); thresh_wr = 1'b1; end
    mon_vsync = 1'b1; tick(); thresh_wr = 1'b0;
    chk("thr_at_sof", thresh_out, thr_next);
    thr_cur = thr_next;
    if (wr_line == -2) thr_next = wr_val;
    for (int l = 0; l < nl; l++) begin
      mon_hsync = 1'b1; tick();
      if (l == wr_line) begin
        thresh_cfg = 8'(wr_val); thresh_wr = 1'b1; tick(); thresh_wr = 1'b0;
        thr_next = wr_val;
      end
      if (l == stop_line) begin
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        chk("start_ignored_cnt", frame_cnt, m_cnt);
        chk("start_ignored_busy", busy, 1);
      end
      for (int p = 0; p < w[l]; p++) begin mon_valid = 1'b1; tick(); end
      mon_valid = 1'b0; tick();
      mon_hsync = 1'b0; tick(2);
    end
    chk("thr_in_frame", thresh_out, thr_cur);
    mon_vsync = 1'b0; tick();
    for (int l = 0; l < nl; l++) begin
      if (w[l] != 0) begin
        if (lines == 0) first = w[l];
        lines++;
        if (w[l] != int'(exp_xres)) bad = 1'b1;
      end
    end
    if (first >= 0) m_mx = first;
    m_my = lines;
    if (lines != int'(exp_yres)) bad = 1'b1;
    m_err = m_err | bad;
    m_cnt = (m_cnt + 1) % 256;
    chk("eof_frame_cnt", frame_cnt, m_cnt);
    chk("eof_meas_y", meas_yres, m_my);
    chk("eof_err_res", err_res, m_err);
    src_done = 1'b1; tick(); src_done = 1'b0;
  endtask

  task automatic wait_done(input int e_cnt, input int e_mx, input int e_my, input bit e_err,
                           input bit e_to);
    int t = 0;
    while (!run_done && t < 400) begin tick(); t++; end
    chk("run_done_seen", run_done, 1);
    chk("done_idle", busy, 0);
    chk("done_frame_cnt", frame_cnt, e_cnt);
    chk("done_meas_x", meas_xres, e_mx);
    chk("done_meas_y", meas_yres, e_my);
    chk("done_err_res", err_res, e_err);
    chk("done_err_to", err_timeout, e_to);
    tick();
    chk("run_done_width", run_done, 0);
    thr_cur = thr_next;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_src_begin"}, src_begin, 0);
    chk({tag, "_thresh"}, thresh_out, 128);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_meas"}, {meas_xres, meas_yres}, 0);
    chk({tag, "_errs"}, {err_res, err_timeout}, 0);
    chk({tag, "_run_done"}, run_done, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wl_t w;
    int t, nf, xr, yr, nl, wl, r;

    vec[0] = '{2, 8, 4, 4, -1, 0,  0,  1, 200, 2, 8, 4, 1'b0};
    vec[1] = '{2, 8, 4, 4,  2, 7,  1, -2,  55, 2, 8, 4, 1'b1};
    vec[2] = '{1, 8, 4, 5, -1, 0, -1, -1,   0, 1, 8, 5, 1'b1};
    vec[3] = '{1, 6, 3, 3,  0, 9, -1, -1,   0, 1, 9, 3, 1'b1};
    vec[4] = '{1, 1, 1, 1, -1, 0, -1, -1,   0, 1, 1, 1, 1'b0};

    rst = 1'b1; start = 1'b0; stop = 1'b0; thresh_wr = 1'b0; thresh_cfg = 8'd0;
    src_done = 1'b0; mon_vsync = 1'b0; mon_hsync = 1'b0; mon_valid = 1'b0;
    num_frames = 8'd0; exp_xres = 16'd8; exp_yres = 16'd4;
    thr_cur = 128; thr_next = 128;
    tick(2);
    chk_reset_state("reset");
    rst = 1'b0; tick();

    for (int i = 0; i < 5; i++) begin
      run(vec[i].nf, vec[i].xr, vec[i].yr);
      for (int f = 0; f < vec[i].nf; f++) begin
        for (int l = 0; l < MAXL; l++) w[l] = (l == vec[i].bad_line) ? vec[i].bad_w : vec[i].xr;
        do_frame(vec[i].nl, w, (f == vec[i].wr_frame) ? vec[i].wr_line : -1, vec[i].wr_val, -1);
      end
      wait_done(vec[i].e_cnt, vec[i].e_mx, vec[i].e_my, vec[i].e_err, 1'b0);
    end

    for (int k = 0; k < 6; k++) begin
      nf = $urandom_range(1, 3); xr = $urandom_range(1, 10); yr = $urandom_range(1, 5);
      run(nf, xr, yr);
      for (int f = 0; f < nf; f++) begin
        nl = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : yr;
        for (int l = 0; l < MAXL; l++) w[l] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 10) : xr;
        r = $urandom_range(0, 5);
        wl = (r == 0) ? 0 : (r == 1) ? -2 : -1;
        do_frame(nl, w, wl, $urandom_range(0, 255), -1);
      end
      wait_done(m_cnt, m_mx, m_my, m_err, 1'b0);
    end

    // reset while the begin pulse is high drops it before the clock edge
    run(1, 8, 4);
    rst = 1'b1; #1;
    chk("rst_begin_drop", src_begin, 0);
    tick(); rst = 1'b0; tick();
    chk("rst_begin_idle", busy, 0);
    thr_cur = 128; thr_next = 128;

    // idle threshold write: pending first, output one cycle later
    thresh_cfg = 8'd77; thresh_wr = 1'b1; tick(); thresh_wr = 1'b0;
    chk("thr_idle_lag", thresh_out, 128);
    tick();
    chk("thr_idle_follow", thresh_out, 77);
    thr_cur = 77; thr_next = 77;

    // start and stop together in idle: stop wins
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 0);
    tick(5);
    chk("start_stop_no_begin", src_begin, 0);

    // stall in the second frame
    run(3, 8, 2);
    for (int l = 0; l < MAXL; l++) w[l] = 8;
    do_frame(2, w, -1, 0, -1);
    wait_begin(); tick(2);
    mon_vsync = 1'b1; tick(); mon_hsync = 1'b1; tick();
    repeat (3) begin mon_valid = 1'b1; tick(); end
    mon_valid = 1'b0;
    t = 0;
    while (!run_done && t < TO + 20) begin tick(); t++; end
    chk("stall_cycles", t, TO);
    chk("stall_err_to", err_timeout, 1);
    chk("stall_frame_cnt", frame_cnt, 1);
    chk("stall_idle", busy, 0);
    chk("stall_err_res", err_res, 0);
    tick();
    chk("stall_done_width", run_done, 0);
    mon_hsync = 1'b0; mon_vsync = 1'b0; tick(2);

    // continuous run stopped during frame 3, with an ignored start
    run(0, 8, 2);
    do_frame(2, w, -1, 0, -1);
    do_frame(2, w, -1, 0, -1);
    do_frame(2, w, -1, 0, 0);
    wait_done(3, 8, 2, 1'b0, 1'b0);
    t = 0;
    repeat (40) begin tick(); if (src_begin) t++; end
    chk("stop_no_restart", t, 0);

    // reset in the middle of an active frame
    run(2, 8, 4);
    do_frame(4, w, -1, 0, -1);
    wait_begin(); tick(2);
    mon_vsync = 1'b1; tick(); mon_hsync = 1'b1; mon_valid = 1'b1; tick(3);
    chk("pre_rst_thresh", thresh_out, 77);
    rst = 1'b1; tick();
    chk_reset_state("rst_active");
    rst = 1'b0; mon_valid = 1'b0; mon_hsync = 1'b0; mon_vsync = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
